// File: rtl/chess_pkg.sv
// Shared chess board definitions used by the move-generator accelerators:
// piece codes, ray direction table, square indexing and colour helpers.
package chess_pkg;

    localparam int BOARD_SQUARES = 64;

    localparam logic signed [7:0] EMPTY     = 8'sd0;
    localparam logic signed [7:0] QUEEN_MIN = 8'sd39;
    localparam logic signed [7:0] QUEEN_MAX = 8'sd47;
    localparam logic signed [7:0] KING      = 8'sd48;

    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_SRC  = 4'd1;
    localparam logic [3:0] REG_DST  = 4'd2;
    localparam logic [3:0] REG_X    = 4'd3;
    localparam logic [3:0] REG_Y    = 4'd4;

    typedef enum logic [2:0] {
        Q_IDLE,
        Q_LOAD,
        Q_SCAN,
        Q_EMIT,
        Q_DONE
    } queen_state_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_RD_REQ,
        DMA_RD_WAIT,
        DMA_WR
    } dma_state_t;

    // Ray order: N, NE, E, SE, S, SW, W, NW
    function automatic logic signed [3:0] dir_dx(input logic [2:0] dir);
        case (dir)
            3'd1, 3'd2, 3'd3: dir_dx = 4'sd1;
            3'd5, 3'd6, 3'd7: dir_dx = -4'sd1;
            default:          dir_dx = 4'sd0;
        endcase
    endfunction

    function automatic logic signed [3:0] dir_dy(input logic [2:0] dir);
        case (dir)
            3'd0, 3'd1, 3'd7: dir_dy = 4'sd1;
            3'd3, 3'd4, 3'd5: dir_dy = -4'sd1;
            default:          dir_dy = 4'sd0;
        endcase
    endfunction

    function automatic logic [5:0] square_index(input logic [2:0] x, input logic [2:0] y);
        return {y, x};
    endfunction

    function automatic logic is_white(input logic [7:0] piece);
        return !piece[7] && (piece != 8'h00);
    endfunction

    function automatic logic is_black(input logic [7:0] piece);
        return piece[7];
    endfunction

endpackage

// File: rtl/board_dma.sv
// Avalon-MM byte sequencer: reads a 64-byte board one byte at a time, or
// writes one back with two byte positions replaced by override values.
module board_dma
    import chess_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_read,
    input  logic        start_write,
    input  logic [31:0] base_addr,
    output logic [5:0]  byte_idx,
    input  logic [7:0]  board_byte,
    input  logic [5:0]  ovr0_idx,
    input  logic [7:0]  ovr0_val,
    input  logic [5:0]  ovr1_idx,
    input  logic [7:0]  ovr1_val,
    output logic        cap_valid,
    output logic [5:0]  cap_idx,
    output logic [7:0]  cap_data,
    output logic        done,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam logic [5:0] LAST_IDX = 6'(BOARD_SQUARES - 1);

    dma_state_t  state_reg, state_next;
    logic [5:0]  idx_reg, idx_next;
    logic [31:0] base_reg, base_next;
    logic [7:0]  wr_byte;
    logic        unused_readdata_hi;

    assign unused_readdata_hi = ^master_readdata[31:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DMA_IDLE;
            idx_reg   <= '0;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            base_reg  <= base_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        base_next  = base_reg;
        case (state_reg)
            DMA_IDLE: begin
                if (start_read || start_write) begin
                    base_next  = base_addr;
                    idx_next   = '0;
                    state_next = start_read ? DMA_RD_REQ : DMA_WR;
                end
            end
            DMA_RD_REQ: begin
                if (!master_waitrequest) state_next = DMA_RD_WAIT;
            end
            DMA_RD_WAIT: begin
                if (master_readdatavalid) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DMA_IDLE;
                    end else begin
                        idx_next   = idx_reg + 6'd1;
                        state_next = DMA_RD_REQ;
                    end
                end
            end
            DMA_WR: begin
                if (!master_waitrequest) begin
                    if (idx_reg == LAST_IDX) state_next = DMA_IDLE;
                    else                     idx_next   = idx_reg + 6'd1;
                end
            end
            default: state_next = DMA_IDLE;
        endcase
    end

    // Target override wins over source override; they never coincide anyway.
    always_comb begin
        if (idx_reg == ovr1_idx)      wr_byte = ovr1_val;
        else if (idx_reg == ovr0_idx) wr_byte = ovr0_val;
        else                          wr_byte = board_byte;
    end

    always_comb begin
        master_read      = (state_reg == DMA_RD_REQ);
        master_write     = (state_reg == DMA_WR);
        master_address   = (master_read || master_write) ? base_reg + {26'd0, idx_reg} : 32'd0;
        master_writedata = master_write ? {24'd0, wr_byte} : 32'd0;
        byte_idx         = idx_reg;
        cap_valid        = (state_reg == DMA_RD_WAIT) && master_readdatavalid;
        cap_idx          = idx_reg;
        cap_data         = master_readdata[7:0];
        done             = (idx_reg == LAST_IDX) &&
                           (cap_valid || (master_write && !master_waitrequest));
    end

endmodule

// File: rtl/queen.sv
// Queen move generator: loads a board, walks the eight rays from the queen
// square and writes one successor board per pseudo-legal move.
module queen
    import chess_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    queen_state_t      state_reg, state_next;
    logic [31:0]       src_reg, dst_reg;
    logic [2:0]        x_reg, y_reg;
    logic [7:0]        count_reg;
    logic [3:0]        dir_reg;
    logic signed [3:0] cur_x_reg, cur_y_reg;
    logic [5:0]        tgt_reg;
    logic [7:0]        board_mem [BOARD_SQUARES];

    logic              start_cmd;
    logic [5:0]        src_sq, tgt_sq, dma_byte_idx;
    logic [7:0]        src_piece, tgt_piece;
    logic signed [3:0] nx, ny;
    logic              off_board, tgt_own, scan_done, scan_emit, ray_end;
    logic              dma_start_rd, dma_start_wr, dma_done, cap_valid;
    logic [5:0]        cap_idx;
    logic [7:0]        cap_data;
    logic [31:0]       dma_base;

    assign start_cmd = (state_reg == Q_IDLE) && slave_write && (slave_address == REG_CTRL);

    always_comb begin
        src_sq    = square_index(x_reg, y_reg);
        src_piece = board_mem[src_sq];
        nx        = cur_x_reg + dir_dx(dir_reg[2:0]);
        ny        = cur_y_reg + dir_dy(dir_reg[2:0]);
        // Coordinates span -1..8, so bit 3 set means off the board either side.
        off_board = nx[3] || ny[3];
        tgt_sq    = square_index(nx[2:0], ny[2:0]);
        tgt_piece = board_mem[tgt_sq];
        tgt_own   = (tgt_piece != 8'h00) && (is_white(tgt_piece) == is_white(src_piece));
        scan_done = dir_reg[3] || (src_piece == 8'h00);
        scan_emit = (state_reg == Q_SCAN) && !scan_done && !off_board && !tgt_own;
        ray_end   = off_board || (tgt_piece != 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= Q_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            Q_IDLE: if (start_cmd) state_next = Q_LOAD;
            Q_LOAD: if (dma_done)  state_next = Q_SCAN;
            Q_SCAN: begin
                if (scan_done)      state_next = Q_DONE;
                else if (scan_emit) state_next = Q_EMIT;
            end
            Q_EMIT: if (dma_done)  state_next = Q_SCAN;
            Q_DONE: state_next = Q_IDLE;
            default: state_next = Q_IDLE;
        endcase
    end

    always_comb begin
        dma_start_rd      = start_cmd;
        dma_start_wr      = scan_emit;
        dma_base          = start_cmd ? src_reg : dst_reg + {18'd0, count_reg, 6'd0};
        slave_waitrequest = 1'b0;
        slave_readdata    = 32'd0;
        if (state_reg == Q_IDLE || state_reg == Q_DONE) begin
            if (slave_read && slave_address == REG_CTRL) slave_readdata = {24'd0, count_reg};
            if (state_reg == Q_DONE && (slave_write || (slave_read && slave_address != REG_CTRL)))
                slave_waitrequest = 1'b1;
        end else if (slave_read || slave_write) begin
            slave_waitrequest = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            count_reg <= '0;
            dir_reg   <= '0;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
            tgt_reg   <= '0;
        end else begin
            if (state_reg == Q_IDLE && slave_write) begin
                case (slave_address)
                    REG_SRC: src_reg <= slave_writedata;
                    REG_DST: dst_reg <= slave_writedata;
                    REG_X:   x_reg   <= slave_writedata[2:0];
                    REG_Y:   y_reg   <= slave_writedata[2:0];
                    default: ;
                endcase
            end
            if (start_cmd) begin
                count_reg <= '0;
                dir_reg   <= '0;
                cur_x_reg <= $signed({1'b0, x_reg});
                cur_y_reg <= $signed({1'b0, y_reg});
            end
            if (state_reg == Q_SCAN && !scan_done) begin
                if (scan_emit) tgt_reg <= tgt_sq;
                // A capture or blocker ends the ray; an empty square keeps walking.
                if (ray_end || tgt_own) begin
                    dir_reg   <= dir_reg + 4'd1;
                    cur_x_reg <= $signed({1'b0, x_reg});
                    cur_y_reg <= $signed({1'b0, y_reg});
                end else begin
                    cur_x_reg <= nx;
                    cur_y_reg <= ny;
                end
            end
            if (state_reg == Q_EMIT && dma_done) count_reg <= count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_valid) board_mem[cap_idx] <= cap_data;
    end

    board_dma u_board_dma (
        .clk                  (clk),
        .rst                  (rst),
        .start_read           (dma_start_rd),
        .start_write          (dma_start_wr),
        .base_addr            (dma_base),
        .byte_idx             (dma_byte_idx),
        .board_byte           (board_mem[dma_byte_idx]),
        .ovr0_idx             (src_sq),
        .ovr0_val             (8'h00),
        .ovr1_idx             (tgt_reg),
        .ovr1_val             (src_piece),
        .cap_valid            (cap_valid),
        .cap_idx              (cap_idx),
        .cap_data             (cap_data),
        .done                 (dma_done),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

endmodule

// File: tb/tb_queen.sv
// Bench for queen: SDRAM model with random stalls, reference move list built
// directly from the ray rules, one line printed per generation run.
module tb_queen;

    logic        clk;
    logic        rst;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    logic [7:0] mem [0:4095];
    logic [7:0] tb_board [0:63];
    int         exp_tgts [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         wr_count = 0;
    bit         stall_en = 0;
    bit         rd_pending = 0;
    int         rd_delay = 0;
    logic [31:0] rd_addr = 0;

    int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    queen dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    // SDRAM model: accepts at posedge, drives responses and stalls at negedge.
    initial begin
        logic [31:0] junk;
        master_waitrequest   = 0;
        master_readdatavalid = 0;
        master_readdata      = 0;
        forever begin
            @(posedge clk);
            if (master_read && master_write) begin
                miscompares++;
                $error("FAIL bus_exclusive observed=both_strobes expected=one");
            end
            if (master_write && !master_waitrequest) begin
                mem[master_address[11:0]] = master_writedata[7:0];
                wr_count++;
            end
            if (master_read && !master_waitrequest) begin
                rd_pending = 1;
                rd_addr    = master_address;
                rd_delay   = stall_en ? $urandom_range(0, 3) : 0;
            end
            if (rst) rd_pending = 0;
            @(negedge clk);
            master_readdatavalid = 0;
            master_readdata      = 0;
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    junk                 = $urandom;
                    master_readdatavalid = 1;
                    master_readdata      = {junk[31:8], mem[rd_addr[11:0]]};
                    rd_pending           = 0;
                end else begin
                    rd_delay--;
                end
            end
            master_waitrequest = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d);
        int waited = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1;
        #1;
        while (slave_waitrequest && waited < 20000) begin
            @(negedge clk); #1; waited++;
        end
        if (waited >= 20000) timeout_fail("slave_write");
        @(posedge clk); #1;
        slave_write = 0;
    endtask

    task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        slave_address = a; slave_read = 1;
        #1;
        while (slave_waitrequest && waited < 20000) begin
            @(negedge clk); #1; waited++;
        end
        if (waited >= 20000) timeout_fail("slave_read");
        d = slave_readdata;
        @(posedge clk); #1;
        slave_read = 0;
    endtask

    // Reference: walk each ray from the queen square using the move rules.
    task automatic build_expect(input int qx, input int qy);
        int own, p, x, y;
        exp_tgts.delete();
        own = int'($signed(tb_board[qy*8+qx]));
        if (own == 0) return;
        for (int d = 0; d < 8; d++) begin
            for (int s = 1; s < 8; s++) begin
                x = qx + s*dxs[d];
                y = qy + s*dys[d];
                if (x < 0 || x > 7 || y < 0 || y > 7) break;
                p = int'($signed(tb_board[y*8+x]));
                if (p == 0) begin
                    exp_tgts.push_back(y*8+x);
                end else if ((p > 0) != (own > 0)) begin
                    exp_tgts.push_back(y*8+x);
                    break;
                end else begin
                    break;
                end
            end
        end
    endtask

    task automatic run_case(input string name, input int qx, input int qy,
                            input int src, input int dst, output int waited);
        logic [31:0]  cnt;
        logic [511:0] obs, exp;
        int           n, wr0, sq;
        for (int i = 0; i < 1728; i++) mem[(dst+i) & 4095] = 8'hA5;
        for (int i = 0; i < 64; i++)   mem[(src+i) & 4095] = tb_board[i];
        build_expect(qx, qy);
        n   = exp_tgts.size();
        sq  = qy*8 + qx;
        wr0 = wr_count;
        slave_wr(4'd1, src);
        slave_wr(4'd2, dst);
        slave_wr(4'd3, qx);
        slave_wr(4'd4, qy);
        slave_wr(4'd0, 0);
        slave_rd(4'd0, cnt, waited);
        check({name, ":count"}, cnt, n);
        check({name, ":writes"}, wr_count - wr0, 64*n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 64; i++) begin
                exp[i*8 +: 8] = tb_board[i];
                obs[i*8 +: 8] = mem[(dst + k*64 + i) & 4095];
            end
            exp[sq*8 +: 8]          = 8'h00;
            exp[exp_tgts[k]*8 +: 8] = tb_board[sq];
            check($sformatf("%s:board%0d", name, k), obs, exp);
        end
        $display("case %s: queen=(%0d,%0d) count=%0d expected=%0d writes=%0d",
                 name, qx, qy, cnt, n, wr_count - wr0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) tb_board[i] = 8'h00;
    endtask

    initial begin
        logic [31:0] rd;
        int          waited, wr0, budget;
        logic [7:0]  piece;

        rst = 1;
        slave_address = 0; slave_read = 0; slave_write = 0; slave_writedata = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {master_read, master_write, master_address, master_writedata, slave_waitrequest, slave_readdata},
              '0);
        @(negedge clk);
        rst = 0;
        slave_rd(4'd0, rd, waited);
        check("reset_count", rd, 0);

        // Lone white queen at (6,3), SRC = DST = 0
        clear_board(); tb_board[30] = 8'd39;
        run_case("open_63", 6, 3, 0, 0, waited);

        // Corner queen: first board must put the queen on square 8 (N ray)
        clear_board(); tb_board[0] = 8'd39;
        run_case("corner_00", 0, 0, 32'h100, 32'h400, waited);
        check("corner_first_tgt", mem[12'h400 + 8], 8'd39);

        // Surrounded by own pawns: no moves
        clear_board(); tb_board[30] = 8'd39;
        for (int d = 0; d < 8; d++) tb_board[(3+dys[d])*8 + 6+dxs[d]] = 8'd1;
        run_case("boxed", 6, 3, 32'h100, 32'h400, waited);

        // Black rook above, white pawn to the west
        clear_board(); tb_board[30] = 8'd39; tb_board[46] = 8'hF7; tb_board[28] = 8'd1;
        run_case("rook_pawn", 6, 3, 32'h100, 32'h400, waited);
        check("rook_capture", mem[12'h400 + 64 + 46], 8'd39);

        // Empty source square returns promptly, then a valid start works
        clear_board(); tb_board[30] = 8'd39;
        run_case("empty_src", 2, 2, 32'h100, 32'h400, waited);
        check("empty_src_prompt", waited < 400, 1'b1);
        tb_board[18] = 8'hD9;
        run_case("black_22", 2, 2, 32'h100, 32'h400, waited);

        // Same open board with bus stalls and late read data
        stall_en = 1;
        clear_board(); tb_board[30] = 8'd39;
        run_case("open_stall", 6, 3, 32'h100, 32'h400, waited);

        for (int r = 0; r < 4; r++) begin
            int qx, qy;
            clear_board();
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    piece = 8'($urandom_range(1, 48));
                    tb_board[i] = $urandom_range(0, 1) ? piece : 8'(-piece);
                end
            end
            qx = $urandom_range(0, 7);
            qy = $urandom_range(0, 7);
            piece = 8'($urandom_range(39, 47));
            tb_board[qy*8+qx] = $urandom_range(0, 1) ? piece : 8'(-piece);
            run_case($sformatf("random%0d", r), qx, qy, 32'h100, 32'h400, waited);
        end

        // Reset in the middle of emitting boards
        clear_board(); tb_board[30] = 8'd39;
        for (int i = 0; i < 64; i++) mem[12'h100 + i] = tb_board[i];
        slave_wr(4'd1, 32'h100);
        slave_wr(4'd2, 32'h400);
        slave_wr(4'd3, 6);
        slave_wr(4'd4, 3);
        wr0 = wr_count;
        slave_wr(4'd0, 0);
        budget = 0;
        while (wr_count == wr0 && budget < 5000) begin
            @(negedge clk); budget++;
        end
        if (budget >= 5000) timeout_fail("emit_start");
        rst = 1;
        @(posedge clk); #1;
        check("reset_strobes", {master_read, master_write, master_address}, '0);
        @(negedge clk);
        rst = 0;
        wr0 = wr_count;
        repeat (20) @(negedge clk);
        check("reset_no_writes", wr_count, wr0);
        slave_rd(4'd0, rd, waited);
        check("reset_idle_count", rd, 0);
        check("reset_idle_prompt", waited, 0);

        stall_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/queen.md
Name: queen

Overview:
- Avalon-MM accelerator that generates all pseudo-legal queen moves for one piece on a chess board held in SDRAM.
- Software programs the source board address, the destination buffer address and the queen's (x,y) square through the slave port, then starts the block.
- The block reads the 64-byte board over its master port and writes one full 64-byte successor board per legal move, contiguously into the destination buffer.

Parameters:
- none; board size is fixed at 8x8, one signed byte per square.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- slave_waitrequest  out  1  stall for the current slave access
- slave_address  in  4  word register index
- slave_read  in  1  slave read strobe
- slave_readdata  out  32  slave read data
- slave_write  in  1  slave write strobe
- slave_writedata  in  32  slave write data
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  byte address
- master_read  out  1  master read strobe
- master_readdata  in  32  read data; bits [7:0] hold the byte
- master_readdatavalid  in  1  read data valid
- master_write  out  1  master write strobe
- master_writedata  out  32  write data; byte in [7:0], upper bits 0

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named rst.
- Board encoding: square index = y*8 + x. Bytes are signed: 0 = empty, >0 = white, <0 = black. Queen codes are +/-39..47; kings are +/-48.
- Slave registers:
  - 1 = SRC, board base address.
  - 2 = DST, output buffer base address.
  - 3 = X, bits [2:0] used.
  - 4 = Y, bits [2:0] used.
  - 0 = control/status: a write starts generation; a read returns COUNT, the number of boards written.
  - Writes to 1-4 while idle complete with waitrequest low in the same cycle.
- Busy rules:
  - While busy, every slave access holds waitrequest high.
  - A read of register 0 stalls until done, then returns COUNT with waitrequest low for one cycle.
  - Reads of other addresses return 0.
- FSM:
  - IDLE -> LOAD on a write to 0.
  - LOAD: 64 single-byte reads at SRC+i, one outstanding read at a time. master_read and master_address are held until master_waitrequest is low. The byte is captured on master_readdatavalid.
  - LOAD -> SCAN.
  - SCAN walks 8 rays in fixed order: N(+y), NE, E(+x), SE, S, SW, W, NW.
  - Each ray steps until off board. If the target is empty, emit a board. If the target holds an opponent piece, emit a board, then end the ray. If the target holds an own piece, end the ray without emitting.
  - Own colour = sign of board[Y*8+X].
  - EMIT: write 64 bytes to DST + COUNT*64 + i. The emitted board equals the loaded board except source = 0 and target = queen code. Each write is held until master_waitrequest is low. Afterwards COUNT++ and the block returns to SCAN.
  - After the last ray, go to DONE; a pending status read is released and the FSM returns to IDLE.
- Boundary cases:
  - If the source square is empty, COUNT = 0 and there are no master writes.
  - No check or king-safety test is made; king captures are emitted like any other capture.
  - COUNT is cleared on start. The maximum is 27 boards, so the buffer is 1728 bytes.
- Reset values: FSM IDLE; all master strobes 0; master_address 0; master_writedata 0; slave_waitrequest 0; slave_readdata 0; registers and COUNT 0.
  - Reset mid-operation aborts immediately with no further bus cycles.
- Master read and write are never asserted together.

Decomposition:
- Package chess_pkg:
  - piece constants: EMPTY, W/B PAWN..KING code ranges, queen range, KING=48;
  - 8-direction dx/dy table;
  - square-index function;
  - is_white / is_black helpers.
- One sub-module, board_dma: a byte read/write Avalon master sequencer (read 64 / write 64 with an override at two indices). It is reused by the other piece generators.

Test Plan:
- Empty board except white queen (39) at x=6,y=3; SRC=0, DST=0 -> COUNT=23. Exactly 23 distinct boards, each with 0 at index 30 and 39 at the target.
- White queen at (0,0) on an empty board -> COUNT=21. The first board emitted has the queen at index 8 (N ray first).
- Queen at (6,3) surrounded by 8 white pawns -> COUNT=0. Zero master writes; the status read returns 0.
- Queen at (6,3) with black rook (-9) at (6,5) and white pawn at (4,3) -> the N ray stops after capturing at index 46, emitting 2 boards with -9 overwritten. The W ray yields only (5,3).
- Empty source square -> COUNT=0, returned promptly; a second start with a valid square works.
- Random master_waitrequest stalls and delayed readdatavalid -> identical output boards. Assert rst mid-EMIT -> strobes drop the next cycle and the block returns to IDLE.
